light_timer_display: RTL and testbench
======================================

LIGHT_TIMER_DISPLAY -- requirements
Module: light_timer_display

Interface
REQ-001 Parameter CLK_FREQ, 100_000_000, clk cycles per 1-s tick.
REQ-002 Parameter SCAN_DIV, 100_000, clk cycles per display digit slot.
REQ-003 Parameter G_ORD_M/G_ORD_S, 20/15, main/sub green seconds, ordinary mode.
REQ-004 Parameter G_BUSY_M/G_BUSY_S, 30/10, main/sub green seconds, busy mode.
REQ-005 Parameter Y_TIME, 3, yellow seconds, both roads.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  system clock, all logic on rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 run  in  1  1 = power on, 0 = all dark.
REQ-010 busy, night, pause, online  in  1 each  mode requests.
REQ-011 LED16, LED17  out  3  main/sub lamp {R,G,B}, active-high; red 100, green 010, yellow 110, dark 000.
REQ-012 SIG_C  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-013 AN  out  8  digit anodes, active-low.

Function
REQ-014 Mode priority: reset > !run (OFF) > online > pause > night > busy > ordinary.
REQ-015 Phases P0 main G/sub R, P1 main Y/sub R, P2 main R/sub G, P3 main R/sub Y, cycling P0-P1-P2-P3-P0.
REQ-016 Phase durations: P0 G_x_M, P1 Y_TIME, P2 G_x_S, P3 Y_TIME; x = BUSY if busy, else ORD, sampled when the phase is loaded.
REQ-017 Tick counter 0..CLK_FREQ-1 produces a 1-cycle tick at terminal count; counter holds in pause/online, clears in OFF.
REQ-018 On tick, phase remaining > 1 decrements; remaining == 1 advances phase and loads its full duration.
REQ-019 Main countdown = remaining in P0/P1; remaining + Y_TIME in P2; remaining in P3. Sub countdown is symmetric (P2/P3 own; P0 adds Y_TIME).
REQ-020 Countdowns are shown as 2-digit BCD 00..99; durations above 99 are outside the supported range.
REQ-021 OFF: lamps 000, AN = FF, phase P0 loaded with its full duration; leaving OFF starts P0 at full count.
REQ-022 Pause: phase, remaining, tick counter and lamps frozen; display keeps the frozen values; release resumes exactly.
REQ-023 Online: LED16 green, LED17 red; timers frozen; display blank (AN = FF); release resumes the frozen phase.
REQ-024 Night: both lamps yellow for the first half of each second, dark for the second half; display blank; on release, restart at P0 full count.
REQ-025 Display scan: every SCAN_DIV cycles advance the active digit AN[7] main tens, AN[6] main ones, AN[1] sub tens, AN[0] sub ones, repeat; exactly one anode low; other anodes high; dp off.
REQ-026 Segment codes for 0-9 use the standard 7-segment font, active-low.
REQ-027 A mode change takes effect on the clock edge after the input changes; lamp outputs are registered.

Reset
REQ-028 Reset forces state as OFF; on the first edge after reset deasserts with run = 1, the block starts P0 at full count, tick counter 0, scan at AN[7].
REQ-029 Reset mid-phase, mid-pause or mid-night discards all timing state.

Structure
REQ-030 Shared package holds the phase enum, the LED code constants and the BCD-to-segment table.
REQ-031 One sub-module seg7_scan (BCD digits in, SIG_C/AN out) is required; phase/timer logic is in the top module.

Verification (CLK_FREQ=10, SCAN_DIV=2, defaults otherwise)
REQ-032 Reset, run=1 -> LED16=010, LED17=100, main count 20, sub 23; after 200 cycles -> P1, LED16=110, main 3.
REQ-033 Full ordinary cycle -> phase durations 20/3/15/3 s; busy=1 before P0 load -> main green 30 s.
REQ-034 Pause at main 12 for 50 cycles -> outputs unchanged; release -> 11 after 10 cycles.
REQ-035 Night=1 -> both lamps 110 for 5 cycles then 000 for 5 cycles, AN=FF; release -> P0, main 20.
REQ-036 Online=1 during P2 -> LED16=010, LED17=100, AN=FF; release -> P2 resumes with prior remaining.
REQ-037 Display scan -> AN sequence 7F,BF,FD,FE each 2 cycles with correct digit segments; run=0 -> lamps 000, AN=FF.

Source files
------------

// File: rtl/light_timer_display_pkg.sv
// Shared types and constants for the two-road traffic light controller:
// phase encoding, operating modes, lamp colour codes and the 7-segment font.
package light_timer_display_pkg;

  localparam int unsigned LED_W = 3;
  localparam int unsigned SEG_W = 8;
  localparam int unsigned CD_W  = 7;

  localparam logic [LED_W-1:0] LED_RED = 3'b100;
  localparam logic [LED_W-1:0] LED_GRN = 3'b010;
  localparam logic [LED_W-1:0] LED_YEL = 3'b110;
  localparam logic [LED_W-1:0] LED_OFF = 3'b000;

  typedef enum logic [1:0] {
    PH0_MG_SR,
    PH1_MY_SR,
    PH2_MR_SG,
    PH3_MR_SY
  } phase_e;

  typedef enum logic [2:0] {
    MODE_OFF,
    MODE_ONLINE,
    MODE_PAUSE,
    MODE_NIGHT,
    MODE_RUN
  } mode_e;

  function automatic logic [LED_W-1:0] lamp_main(phase_e p);
    case (p)
      PH0_MG_SR: return LED_GRN;
      PH1_MY_SR: return LED_YEL;
      default:   return LED_RED;
    endcase
  endfunction

  function automatic logic [LED_W-1:0] lamp_sub(phase_e p);
    case (p)
      PH2_MR_SG: return LED_GRN;
      PH3_MR_SY: return LED_YEL;
      default:   return LED_RED;
    endcase
  endfunction

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
  function automatic logic [6:0] seg_code(logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

endpackage

// File: rtl/light_timer_display_if.sv
// Mode request inputs plus lamp and display outputs of the traffic light block.
interface light_timer_display_if;
  import light_timer_display_pkg::*;

  logic             run;
  logic             busy;
  logic             night;
  logic             pause;
  logic             online;
  logic [LED_W-1:0] LED16;
  logic [LED_W-1:0] LED17;
  logic [SEG_W-1:0] SIG_C;
  logic [SEG_W-1:0] AN;

  modport master (
    output run, busy, night, pause, online,
    input  LED16, LED17, SIG_C, AN
  );

  modport slave (
    input  run, busy, night, pause, online,
    output LED16, LED17, SIG_C, AN
  );

endinterface

// File: rtl/light_timer_display_seg7_scan.sv
// Four-digit multiplexed 7-segment driver: main tens/ones on AN[7:6],
// sub tens/ones on AN[1:0], one digit slot every SCAN_DIV cycles.
module seg7_scan
  import light_timer_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             blank,
  input  logic [3:0]       main_tens,
  input  logic [3:0]       main_ones,
  input  logic [3:0]       sub_tens,
  input  logic [3:0]       sub_ones,
  output logic [SEG_W-1:0] seg,
  output logic [SEG_W-1:0] an
);

  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [SW-1:0] slot_cnt_q;
  logic [1:0]    idx_q;
  logic [3:0]    digit_c;
  logic [7:0]    anode_c;

  // Digit and anode for the slot currently being scanned.
  always_comb begin
    digit_c = main_tens;
    anode_c = 8'h7F;
    case (idx_q)
      2'd0:    begin digit_c = main_tens; anode_c = 8'h7F; end
      2'd1:    begin digit_c = main_ones; anode_c = 8'hBF; end
      2'd2:    begin digit_c = sub_tens;  anode_c = 8'hFD; end
      default: begin digit_c = sub_ones;  anode_c = 8'hFE; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      slot_cnt_q <= '0;
      idx_q      <= 2'd0;
      an         <= 8'hFF;
      seg        <= 8'hFF;
    end else begin
      if (slot_cnt_q == SW'(SCAN_DIV - 1)) begin
        slot_cnt_q <= '0;
        idx_q      <= idx_q + 2'd1;
      end else begin
        slot_cnt_q <= slot_cnt_q + SW'(1);
      end
      // Scanning keeps running while blanked so the slot timing never slips.
      if (blank) begin
        an  <= 8'hFF;
        seg <= 8'hFF;
      end else begin
        an  <= anode_c;
        seg <= {1'b1, seg_code(digit_c)};
      end
    end
  end

endmodule

// File: rtl/light_timer_display.sv
// Two-road traffic light controller with per-road countdown display,
// ordinary/busy timing and night, pause, online and power-off modes.
module light_timer_display
  import light_timer_display_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned SCAN_DIV = 100_000,
  parameter int unsigned G_ORD_M  = 20,
  parameter int unsigned G_ORD_S  = 15,
  parameter int unsigned G_BUSY_M = 30,
  parameter int unsigned G_BUSY_S = 10,
  parameter int unsigned Y_TIME   = 3
) (
  input logic                  clk,
  input logic                  reset,
  light_timer_display_if.slave bus
);

  localparam int unsigned TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  phase_e          phase_q;
  logic [CD_W-1:0] rem_q;
  logic [TW-1:0]   tick_cnt_q;
  logic            off_q;

  mode_e           mode_c;
  logic            tick_c;
  phase_e          phase_nx_c;
  logic [TW-1:0]   cnt_inc_c;
  logic [TW-1:0]   cnt_run_c;
  logic [CD_W-1:0] main_cd_c;
  logic [CD_W-1:0] sub_cd_c;

  function automatic logic [CD_W-1:0] dur(phase_e p, logic b);
    case (p)
      PH0_MG_SR: return b ? CD_W'(G_BUSY_M) : CD_W'(G_ORD_M);
      PH2_MR_SG: return b ? CD_W'(G_BUSY_S) : CD_W'(G_ORD_S);
      default:   return CD_W'(Y_TIME);
    endcase
  endfunction

  // Mode priority: power > online > pause > night > normal (busy only picks durations).
  always_comb begin
    mode_c = MODE_RUN;
    if (!bus.run)        mode_c = MODE_OFF;
    else if (bus.online) mode_c = MODE_ONLINE;
    else if (bus.pause)  mode_c = MODE_PAUSE;
    else if (bus.night)  mode_c = MODE_NIGHT;
  end

  // The first running edge after power-off starts the second at count 0.
  assign tick_c     = (tick_cnt_q == TW'(CLK_FREQ - 1));
  assign cnt_inc_c  = tick_c ? '0 : tick_cnt_q + TW'(1);
  assign cnt_run_c  = off_q ? '0 : cnt_inc_c;
  assign phase_nx_c = phase_e'(phase_q + 2'd1);

  // A road waiting for the other's yellow also counts that yellow.
  assign main_cd_c = (phase_q == PH2_MR_SG) ? rem_q + CD_W'(Y_TIME) : rem_q;
  assign sub_cd_c  = (phase_q == PH0_MG_SR) ? rem_q + CD_W'(Y_TIME) : rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= PH0_MG_SR;
      rem_q      <= dur(PH0_MG_SR, bus.busy);
      tick_cnt_q <= '0;
      off_q      <= 1'b1;
      bus.LED16  <= LED_OFF;
      bus.LED17  <= LED_OFF;
    end else begin
      off_q <= (mode_c == MODE_OFF);
      case (mode_c)
        MODE_OFF: begin
          phase_q    <= PH0_MG_SR;
          rem_q      <= dur(PH0_MG_SR, bus.busy);
          tick_cnt_q <= '0;
          bus.LED16  <= LED_OFF;
          bus.LED17  <= LED_OFF;
        end
        MODE_ONLINE: begin
          bus.LED16 <= LED_GRN;
          bus.LED17 <= LED_RED;
        end
        MODE_NIGHT: begin
          phase_q    <= PH0_MG_SR;
          rem_q      <= dur(PH0_MG_SR, bus.busy);
          tick_cnt_q <= cnt_run_c;
          bus.LED16  <= (cnt_run_c < TW'(CLK_FREQ / 2)) ? LED_YEL : LED_OFF;
          bus.LED17  <= (cnt_run_c < TW'(CLK_FREQ / 2)) ? LED_YEL : LED_OFF;
        end
        MODE_RUN: begin
          tick_cnt_q <= cnt_run_c;
          if (off_q) begin
            phase_q   <= PH0_MG_SR;
            rem_q     <= dur(PH0_MG_SR, bus.busy);
            bus.LED16 <= lamp_main(PH0_MG_SR);
            bus.LED17 <= lamp_sub(PH0_MG_SR);
          end else if (tick_c && rem_q <= CD_W'(1)) begin
            phase_q   <= phase_nx_c;
            rem_q     <= dur(phase_nx_c, bus.busy);
            bus.LED16 <= lamp_main(phase_nx_c);
            bus.LED17 <= lamp_sub(phase_nx_c);
          end else begin
            if (tick_c) rem_q <= rem_q - CD_W'(1);
            bus.LED16 <= lamp_main(phase_q);
            bus.LED17 <= lamp_sub(phase_q);
          end
        end
        default: ; // pause: everything holds
      endcase
    end
  end

  seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk       (clk),
    .reset     (reset),
    .enable    (mode_c != MODE_OFF),
    .blank     (mode_c == MODE_NIGHT || mode_c == MODE_ONLINE),
    .main_tens (4'(main_cd_c / CD_W'(10))),
    .main_ones (4'(main_cd_c % CD_W'(10))),
    .sub_tens  (4'(sub_cd_c / CD_W'(10))),
    .sub_ones  (4'(sub_cd_c % CD_W'(10))),
    .seg       (bus.SIG_C),
    .an        (bus.AN)
  );

endmodule

// File: tb/tb_light_timer_display.sv
// Bench for light_timer_display: seconds-level behavioural model compared on
// every cycle, a few hand-computed expectations, then randomized mode traffic.
module tb_light_timer_display;

  localparam int CLK_FREQ = 10;
  localparam int SCAN_DIV = 2;
  localparam int G_ORD_M  = 20;
  localparam int G_ORD_S  = 15;
  localparam int G_BUSY_M = 30;
  localparam int G_BUSY_S = 10;
  localparam int Y_TIME   = 3;

  logic clk;
  logic reset;
  light_timer_display_if bus_if ();

  light_timer_display #(
    .CLK_FREQ (CLK_FREQ),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endfunction

  // Model: which phase, whole seconds left, cycles into the current second.
  int         m_phase, m_rem, m_cyc, m_scan;
  bit         m_off, m_valid;
  logic [2:0] m_led16, m_led17;
  logic [7:0] m_an, m_sig;

  logic [2:0] main_col [4] = '{3'b010, 3'b110, 3'b100, 3'b100};
  logic [2:0] sub_col  [4] = '{3'b100, 3'b100, 3'b010, 3'b110};
  logic [7:0] font     [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [7:0] anodes   [4] = '{8'h7F, 8'hBF, 8'hFD, 8'hFE};

  function automatic int dur_of(int ph, bit b);
    if (ph == 0) return b ? G_BUSY_M : G_ORD_M;
    if (ph == 2) return b ? G_BUSY_S : G_ORD_S;
    return Y_TIME;
  endfunction

  // mode: 0 off, 1 online, 2 pause, 3 night, 4 normal
  task automatic model_step();
    int mc, sc, idx, mode;
    int dg [4];
    bit b;
    b  = bus_if.busy;
    mc = (m_phase == 2) ? m_rem + Y_TIME : m_rem;
    sc = (m_phase == 0) ? m_rem + Y_TIME : m_rem;
    if (reset) begin
      m_phase = 0; m_rem = dur_of(0, b); m_cyc = 0; m_scan = 0; m_off = 1;
      m_led16 = 3'b000; m_led17 = 3'b000; m_an = 8'hFF; m_sig = 8'hFF;
      m_valid = 1;
      return;
    end
    if (!bus_if.run)      mode = 0;
    else if (bus_if.online) mode = 1;
    else if (bus_if.pause)  mode = 2;
    else if (bus_if.night)  mode = 3;
    else                    mode = 4;

    if (mode == 0) begin
      m_an = 8'hFF; m_sig = 8'hFF; m_scan = 0;
    end else begin
      idx = (m_scan / SCAN_DIV) % 4;
      m_scan = (m_scan + 1) % (4 * SCAN_DIV);
      if (mode == 1 || mode == 3) begin
        m_an = 8'hFF; m_sig = 8'hFF;
      end else begin
        dg = '{mc / 10, mc % 10, sc / 10, sc % 10};
        m_an = anodes[idx]; m_sig = font[dg[idx]];
      end
    end

    case (mode)
      0: begin
        m_phase = 0; m_rem = dur_of(0, b); m_cyc = 0;
        m_led16 = 3'b000; m_led17 = 3'b000;
      end
      1: begin m_led16 = 3'b010; m_led17 = 3'b100; end
      3: begin
        m_cyc = m_off ? 0 : (m_cyc + 1) % CLK_FREQ;
        m_phase = 0; m_rem = dur_of(0, b);
        m_led16 = (m_cyc < CLK_FREQ / 2) ? 3'b110 : 3'b000;
        m_led17 = m_led16;
      end
      4: begin
        if (m_off) begin
          m_cyc = 0; m_phase = 0; m_rem = dur_of(0, b);
        end else if (m_cyc == CLK_FREQ - 1) begin
          m_cyc = 0;
          m_rem--;
          if (m_rem == 0) begin
            m_phase = (m_phase + 1) % 4;
            m_rem = dur_of(m_phase, b);
          end
        end else begin
          m_cyc++;
        end
        m_led16 = main_col[m_phase]; m_led17 = sub_col[m_phase];
      end
      default: ;
    endcase
    m_off = (mode == 0);
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("LED16", 8'(bus_if.LED16), 8'(m_led16));
      chk("LED17", 8'(bus_if.LED17), 8'(m_led17));
      chk("AN",    bus_if.AN,        m_an);
      chk("SIG_C", bus_if.SIG_C,     m_sig);
    end
  end

  task automatic cyc(bit r, bit ru, bit b, bit n, bit p, bit o);
    @(negedge clk);
    reset = r; bus_if.run = ru; bus_if.busy = b;
    bus_if.night = n; bus_if.pause = p; bus_if.online = o;
    @(posedge clk);
    model_step();
  endtask

  initial begin
    int ny, nff, len;
    bit r, ru, b, n, p, o;
    m_valid = 0;
    reset = 1'b1;
    bus_if.run = 1'b1; bus_if.busy = 1'b0; bus_if.night = 1'b0;
    bus_if.pause = 1'b0; bus_if.online = 1'b0;

    repeat (3) cyc(1, 1, 0, 0, 0, 0);
    #1;
    chk("rst_led16", 8'(bus_if.LED16), 8'h00);
    chk("rst_an", bus_if.AN, 8'hFF);

    // Edge 1..7 after release: P0, main 20, sub 23, two cycles per digit.
    cyc(0, 1, 0, 0, 0, 0); #1;
    chk("p0_led16", 8'(bus_if.LED16), 8'h02);
    chk("p0_led17", 8'(bus_if.LED17), 8'h04);
    chk("scan0_an", bus_if.AN, 8'h7F);
    chk("scan0_seg", bus_if.SIG_C, 8'hA4);
    cyc(0, 1, 0, 0, 0, 0); #1;
    chk("scan0b_an", bus_if.AN, 8'h7F);
    cyc(0, 1, 0, 0, 0, 0); #1;
    chk("scan1_an", bus_if.AN, 8'hBF);
    chk("scan1_seg", bus_if.SIG_C, 8'hC0);
    repeat (2) cyc(0, 1, 0, 0, 0, 0); #1;
    chk("scan2_an", bus_if.AN, 8'hFD);
    chk("scan2_seg", bus_if.SIG_C, 8'hA4);
    repeat (2) cyc(0, 1, 0, 0, 0, 0); #1;
    chk("scan3_an", bus_if.AN, 8'hFE);
    chk("scan3_seg", bus_if.SIG_C, 8'hB0);

    // 20 s of green ends on edge 201.
    repeat (193) cyc(0, 1, 0, 0, 0, 0); #1;
    chk("e200_led16", 8'(bus_if.LED16), 8'h02);
    cyc(0, 1, 0, 0, 0, 0); #1;
    chk("p1_led16", 8'(bus_if.LED16), 8'h06);
    chk("p1_led17", 8'(bus_if.LED17), 8'h04);
    repeat (2) cyc(0, 1, 0, 0, 0, 0); #1;
    chk("p1_main_an", bus_if.AN, 8'hBF);
    chk("p1_main_ones", bus_if.SIG_C, 8'hB0);

    repeat (50) cyc(0, 1, 0, 0, 1, 0); #1;
    chk("pause_led16", 8'(bus_if.LED16), 8'h06);
    repeat (20) cyc(0, 1, 0, 0, 0, 0);

    cyc(0, 1, 0, 0, 0, 1); #1;
    chk("online_led16", 8'(bus_if.LED16), 8'h02);
    chk("online_led17", 8'(bus_if.LED17), 8'h04);
    chk("online_an", bus_if.AN, 8'hFF);
    repeat (5) cyc(0, 1, 0, 0, 0, 1);
    repeat (15) cyc(0, 1, 0, 0, 0, 0);

    ny = 0; nff = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 1, 0, 0); #1;
      if (bus_if.LED16 == 3'b110 && bus_if.LED17 == 3'b110) ny++;
      if (bus_if.AN == 8'hFF) nff++;
    end
    chk("night_yellow", 8'(ny), 8'd5);
    chk("night_blank", 8'(nff), 8'd10);
    cyc(0, 1, 0, 0, 0, 0); #1;
    chk("night_rel", 8'(bus_if.LED16), 8'h02);

    cyc(0, 0, 0, 0, 0, 0); #1;
    chk("off_led16", 8'(bus_if.LED16), 8'h00);
    chk("off_an", bus_if.AN, 8'hFF);

    // Busy reset: main green 30 s.
    repeat (2) cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0); #1;
    chk("busy_an", bus_if.AN, 8'h7F);
    chk("busy_main_tens", bus_if.SIG_C, 8'hB0);
    repeat (320) cyc(0, 1, 1, 0, 0, 0);

    // Uninterrupted ordinary/busy cycles.
    for (int i = 0; i < 900; i++) cyc(0, 1, (i / 150) % 2 == 1, 0, 0, 0);

    // Randomized mode traffic.
    for (int s = 0; s < 160; s++) begin
      r  = ($urandom_range(99) < 3);
      ru = ($urandom_range(99) >= 6);
      b  = ($urandom_range(99) < 30);
      n  = ($urandom_range(99) < 10);
      p  = ($urandom_range(99) < 12);
      o  = ($urandom_range(99) < 10);
      len = $urandom_range(60, 1);
      repeat (len) cyc(r, ru, b, n, p, o);
    end

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
